regfile_mp: RTL and testbench

- Parametrised multi-port register file for the MIPS pipeline.
- Generalises data width, depth and read-port count over the current 3-read/1-write file, and adds a second write port for dual writeback.
- Adds a per-register busy scoreboard that the ID stage uses for hazard detection.
- Sits between ID (reads, issue) and WB (writes).

---
 rtl/regfile_mp_if.sv | 36 +++
 rtl/regfile_mp.sv | 84 ++++++++
 tb/tb_regfile_mp.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, two writeback ports, issue and flush.
// master = pipeline side (ID/WB), slave = register file.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 3
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [NUM_RD*ADDR_W-1:0] RdAddr;
  logic [NUM_RD*DATA_W-1:0] RdData;
  logic [NUM_RD-1:0]        RdBusy;
  logic                     Wr0En;
  logic [ADDR_W-1:0]        Wr0Addr;
  logic [DATA_W-1:0]        Wr0Data;
  logic                     Wr1En;
  logic [ADDR_W-1:0]        Wr1Addr;
  logic [DATA_W-1:0]        Wr1Data;
  logic                     IssueEn;
  logic [ADDR_W-1:0]        IssueAddr;
  logic                     Flush;

  // No handshake: reads are combinational; writes, issues and flushes are
  // single-cycle strobes that take effect at the next rising clock edge.
  modport master (
    output RdAddr, Wr0En, Wr0Addr, Wr0Data, Wr1En, Wr1Addr, Wr1Data,
           IssueEn, IssueAddr, Flush,
    input  RdData, RdBusy
  );

  modport slave (
    input  RdAddr, Wr0En, Wr0Addr, Wr0Data, Wr1En, Wr1Addr, Wr1Data,
           IssueEn, IssueAddr, Flush,
    output RdData, RdBusy
  );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with dual writeback and per-register busy scoreboard.
// Optional macro REGFILE_BYPASS_EN adds same-cycle write-to-read forwarding.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 3,
  parameter int ZERO_REG = 1
) (
  input  logic          CLK,
  input  logic          RESET,
  regfile_mp_if.slave   bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;
  logic              wr0_ok;
  logic              wr1_ok;
  logic              issue_ok;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_busy;

  // Register 0 is hard-wired when ZERO_REG is set: filter its writes and issues here.
  assign wr0_ok   = bus.Wr0En   && !((ZERO_REG != 0) && (bus.Wr0Addr   == '0));
  assign wr1_ok   = bus.Wr1En   && !((ZERO_REG != 0) && (bus.Wr1Addr   == '0));
  assign issue_ok = bus.IssueEn && !((ZERO_REG != 0) && (bus.IssueAddr == '0));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
    end else begin
      if (wr0_ok) regs[bus.Wr0Addr] <= bus.Wr0Data;
      // Later assignment wins, so port 1 (younger) overrides port 0 on collision.
      if (wr1_ok) regs[bus.Wr1Addr] <= bus.Wr1Data;
    end
  end

  // Applied lowest priority first: write clear, flush, then issue set.
  always_comb begin
    busy_next = busy;
    for (int r = 0; r < DEPTH; r++) begin
      if ((wr0_ok && (bus.Wr0Addr == ADDR_W'(r))) ||
          (wr1_ok && (bus.Wr1Addr == ADDR_W'(r))))
        busy_next[r] = 1'b0;
      if (bus.Flush)
        busy_next[r] = 1'b0;
      if (issue_ok && (bus.IssueAddr == ADDR_W'(r)))
        busy_next[r] = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) busy <= '0;
    else       busy <= busy_next;
  end

  always_comb begin
    bus.RdData = '0;
    bus.RdBusy = '0;
    rd_addr    = '0;
    rd_data    = '0;
    rd_busy    = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_addr = bus.RdAddr[i*ADDR_W +: ADDR_W];
      rd_data = regs[rd_addr];
      rd_busy = busy[rd_addr];
`ifdef REGFILE_BYPASS_EN
      if (wr0_ok && (bus.Wr0Addr == rd_addr)) rd_data = bus.Wr0Data;
      if (wr1_ok && (bus.Wr1Addr == rd_addr)) rd_data = bus.Wr1Data;
      if (((wr0_ok && (bus.Wr0Addr == rd_addr)) || (wr1_ok && (bus.Wr1Addr == rd_addr))) &&
          !(issue_ok && (bus.IssueAddr == rd_addr)))
        rd_busy = 1'b0;
`endif
      if ((ZERO_REG != 0) && (rd_addr == '0)) begin
        rd_data = '0;
        rd_busy = 1'b0;
      end
      bus.RdData[i*DATA_W +: DATA_W] = rd_data;
      bus.RdBusy[i]                  = rd_busy;
    end
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: two instances (default 32x32x3 with ZERO_REG,
// and 16-bit x64 x5 without), expectations queued and checked by a monitor.
module tb_regfile_mp;
  logic CLK;
  logic RESET;
  logic chk_en;

  localparam int EW = 43; // {sel, port[2:0], addr[5:0], busy, data[31:0]}

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_mp_if #(.DATA_W(32), .DEPTH(32), .NUM_RD(3)) bus_a ();
  regfile_mp_if #(.DATA_W(16), .DEPTH(64), .NUM_RD(5)) bus_b ();

  regfile_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(3), .ZERO_REG(1)) dut_a (
    .CLK(CLK), .RESET(RESET), .bus(bus_a)
  );
  regfile_mp #(.DATA_W(16), .DEPTH(64), .NUM_RD(5), .ZERO_REG(0)) dut_b (
    .CLK(CLK), .RESET(RESET), .bus(bus_b)
  );

  // clock / reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  // driver tasks
  task automatic idle();
    bus_a.Wr0En = 1'b0; bus_a.Wr0Addr = '0; bus_a.Wr0Data = '0;
    bus_a.Wr1En = 1'b0; bus_a.Wr1Addr = '0; bus_a.Wr1Data = '0;
    bus_a.IssueEn = 1'b0; bus_a.IssueAddr = '0; bus_a.Flush = 1'b0;
    bus_b.Wr0En = 1'b0; bus_b.Wr0Addr = '0; bus_b.Wr0Data = '0;
    bus_b.Wr1En = 1'b0; bus_b.Wr1Addr = '0; bus_b.Wr1Data = '0;
    bus_b.IssueEn = 1'b0; bus_b.IssueAddr = '0; bus_b.Flush = 1'b0;
  endtask

  task automatic rd_a(input int port, input int addr, input logic [31:0] data, input logic bsy);
    logic [5:0] a6;
    a6 = 6'(addr);
    bus_a.RdAddr[port*5 +: 5] = a6[4:0];
    exp_q.push_back({1'b0, 3'(port), a6, bsy, data});
  endtask

  task automatic rd_b(input int port, input int addr, input logic [15:0] data, input logic bsy);
    logic [5:0] a6;
    a6 = 6'(addr);
    bus_b.RdAddr[port*6 +: 6] = a6;
    exp_q.push_back({1'b1, 3'(port), a6, bsy, 16'h0, data});
  endtask

  task automatic tick();
    chk_en = 1'b1;
    @(posedge CLK);
    #1;
    chk_en = 1'b0;
  endtask

  // scoreboard monitor: samples on the falling edge, away from the active edge
  logic [EW-1:0] e;
  logic          e_sel;
  int            e_port;
  logic [5:0]    e_addr;
  logic          e_busy;
  logic [31:0]   e_data;
  logic [31:0]   act_d;
  logic          act_b;

  always @(negedge CLK) begin
    if (chk_en) begin
      while (exp_q.size() > 0) begin
        e      = exp_q.pop_front();
        e_sel  = e[42];
        e_port = int'(e[41:39]);
        e_addr = e[38:33];
        e_busy = e[32];
        e_data = e[31:0];
        if (!e_sel) begin
          act_d = bus_a.RdData[e_port*32 +: 32];
          act_b = bus_a.RdBusy[e_port];
        end else begin
          act_d = {16'h0, bus_b.RdData[e_port*16 +: 16]};
          act_b = bus_b.RdBusy[e_port];
        end
        checks++;
        if (act_d !== e_data || act_b !== e_busy) begin
          errors++;
          $display("FAIL rd dut=%s port=%0d addr=%0d t=%0t: got data=%h busy=%b, expected data=%h busy=%b",
                   e_sel ? "b" : "a", e_port, e_addr, $time, act_d, act_b, e_data, e_busy);
        end
      end
    end
  end

  initial begin
    chk_en = 1'b0;
    idle();
    bus_a.RdAddr = '0;
    bus_b.RdAddr = '0;

    // reset for 2 cycles while arbitrary writes/issues are presented
    RESET = 1'b1;
    bus_a.Wr0En = 1'b1; bus_a.Wr0Addr = 5'd3; bus_a.Wr0Data = 32'h1234;
    bus_a.IssueEn = 1'b1; bus_a.IssueAddr = 5'd3;
    bus_b.Wr1En = 1'b1; bus_b.Wr1Addr = 6'd40; bus_b.Wr1Data = 16'hAAAA;
    tick();
    tick();
    RESET = 1'b0;
    idle();
    rd_a(0, 3, 32'h0, 1'b0);
    rd_a(1, 5, 32'h0, 1'b0);
    rd_a(2, 31, 32'h0, 1'b0);
    rd_b(0, 40, 16'h0, 1'b0);
    rd_b(4, 63, 16'h0, 1'b0);
    tick();

    // write to a non-busy register
    bus_a.Wr0En = 1'b1; bus_a.Wr0Addr = 5'd5; bus_a.Wr0Data = 32'hDEADBEEF;
    rd_a(0, 5, BYP ? 32'hDEADBEEF : 32'h0, 1'b0);
    tick();
    idle();
    rd_a(0, 5, 32'hDEADBEEF, 1'b0);
    tick();

    // write collision: port 1 wins
    bus_a.Wr0En = 1'b1; bus_a.Wr0Addr = 5'd7; bus_a.Wr0Data = 32'h11111111;
    bus_a.Wr1En = 1'b1; bus_a.Wr1Addr = 5'd7; bus_a.Wr1Data = 32'h22222222;
    rd_a(1, 7, BYP ? 32'h22222222 : 32'h0, 1'b0);
    tick();
    idle();
    rd_a(1, 7, 32'h22222222, 1'b0);
    tick();

    // busy set by issue, cleared by writeback, issue beats same-cycle write
    bus_a.IssueEn = 1'b1; bus_a.IssueAddr = 5'd9;
    rd_a(2, 9, 32'h0, 1'b0);
    tick();
    idle();
    bus_a.Wr1En = 1'b1; bus_a.Wr1Addr = 5'd9; bus_a.Wr1Data = 32'h5;
    rd_a(2, 9, BYP ? 32'h5 : 32'h0, BYP ? 1'b0 : 1'b1);
    tick();
    idle();
    rd_a(2, 9, 32'h5, 1'b0);
    tick();
    bus_a.IssueEn = 1'b1; bus_a.IssueAddr = 5'd9;
    bus_a.Wr0En = 1'b1; bus_a.Wr0Addr = 5'd9; bus_a.Wr0Data = 32'h6;
    rd_a(2, 9, BYP ? 32'h6 : 32'h5, 1'b0);
    tick();
    idle();
    rd_a(2, 9, 32'h6, 1'b1);
    tick();

    // issue 3,4,6 then flush with a same-cycle issue of 4
    bus_a.IssueEn = 1'b1; bus_a.IssueAddr = 5'd3; tick();
    bus_a.IssueAddr = 5'd4; tick();
    bus_a.IssueAddr = 5'd6; tick();
    idle();
    rd_a(0, 3, 32'h0, 1'b1);
    rd_a(1, 4, 32'h0, 1'b1);
    rd_a(2, 6, 32'h0, 1'b1);
    tick();
    bus_a.Flush = 1'b1; bus_a.IssueEn = 1'b1; bus_a.IssueAddr = 5'd4;
    tick();
    idle();
    rd_a(0, 3, 32'h0, 1'b0);
    rd_a(1, 4, 32'h0, 1'b1);
    rd_a(2, 6, 32'h0, 1'b0);
    tick();
    rd_a(2, 9, 32'h6, 1'b0);
    tick();

    // register 0: hard-wired on dut_a, ordinary on dut_b
    bus_a.Wr0En = 1'b1; bus_a.Wr0Addr = 5'd0; bus_a.Wr0Data = 32'hFFFFFFFF;
    bus_a.IssueEn = 1'b1; bus_a.IssueAddr = 5'd0;
    bus_b.Wr0En = 1'b1; bus_b.Wr0Addr = 6'd0; bus_b.Wr0Data = 16'hFFFF;
    bus_b.IssueEn = 1'b1; bus_b.IssueAddr = 6'd0;
    rd_a(0, 0, 32'h0, 1'b0);
    rd_b(0, 0, BYP ? 16'hFFFF : 16'h0, 1'b0);
    tick();
    idle();
    rd_a(0, 0, 32'h0, 1'b0);
    rd_b(0, 0, 16'hFFFF, 1'b1);
    tick();

    // collision with a same-cycle read, both configurations
    bus_a.Wr0En = 1'b1; bus_a.Wr0Addr = 5'd12; bus_a.Wr0Data = 32'hA;
    bus_a.Wr1En = 1'b1; bus_a.Wr1Addr = 5'd12; bus_a.Wr1Data = 32'hB;
    bus_b.Wr0En = 1'b1; bus_b.Wr0Addr = 6'd12; bus_b.Wr0Data = 16'hA;
    bus_b.Wr1En = 1'b1; bus_b.Wr1Addr = 6'd12; bus_b.Wr1Data = 16'hB;
    rd_a(1, 12, BYP ? 32'hB : 32'h0, 1'b0);
    rd_b(4, 12, BYP ? 16'hB : 16'h0, 1'b0);
    rd_b(3, 12, BYP ? 16'hB : 16'h0, 1'b0);
    tick();
    idle();
    rd_a(1, 12, 32'hB, 1'b0);
    rd_b(4, 12, 16'hB, 1'b0);
    rd_b(3, 12, 16'hB, 1'b0);
    rd_b(1, 0, 16'hFFFF, 1'b1);
    tick();

    // mid-operation reset discards data, busy and the same-cycle write/issue
    bus_a.Wr0En = 1'b1; bus_a.Wr0Addr = 5'd20; bus_a.Wr0Data = 32'h77;
    bus_a.IssueEn = 1'b1; bus_a.IssueAddr = 5'd21;
    tick();
    idle();
    RESET = 1'b1;
    bus_a.Wr1En = 1'b1; bus_a.Wr1Addr = 5'd21; bus_a.Wr1Data = 32'h99;
    bus_a.IssueEn = 1'b1; bus_a.IssueAddr = 5'd22;
    tick();
    RESET = 1'b0;
    idle();
    rd_a(0, 20, 32'h0, 1'b0);
    rd_a(1, 21, 32'h0, 1'b0);
    rd_a(2, 22, 32'h0, 1'b0);
    rd_b(0, 0, 16'h0, 1'b0);
    rd_b(2, 12, 16'h0, 1'b0);
    tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
